// File: rtl/mul_pipe.sv
// Three-stage pipelined signed/unsigned multiplier with MADD/MSUB accumulate,
// valid/ready handshake on both sides, flush and an opaque pass-through tag.
module mul_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_sign,
   input  logic [1:0]           in_mode,
   input  logic [2*WIDTH-1:0]   in_acc,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_result,
   output logic [TAG_W-1:0]     out_tag
);

   localparam int unsigned H  = WIDTH / 2;
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned MW = WIDTH + 1;

   typedef enum logic [1:0] {
      MODE_MUL  = 2'b00,
      MODE_MADD = 2'b01,
      MODE_MSUB = 2'b10,
      MODE_RSV  = 2'b11
   } mode_e;

   logic              adv;
   logic              accept;
   logic              sign_a;
   logic              sign_b;

   logic              s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]  s1_abs_a_q, s1_abs_a_d;
   logic [WIDTH-1:0]  s1_abs_b_q, s1_abs_b_d;
   logic              s1_neg_q,   s1_neg_d;
   mode_e             s1_mode_q,  s1_mode_d;
   logic [PW-1:0]     s1_acc_q,   s1_acc_d;
   logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;

   logic              s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0]  s2_ll_q,    s2_ll_d;
   logic [WIDTH-1:0]  s2_lh_q,    s2_lh_d;
   logic [WIDTH-1:0]  s2_hl_q,    s2_hl_d;
   logic [WIDTH-1:0]  s2_hh_q,    s2_hh_d;
   logic              s2_neg_q,   s2_neg_d;
   mode_e             s2_mode_q,  s2_mode_d;
   logic [PW-1:0]     s2_acc_q,   s2_acc_d;
   logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;

   logic              out_valid_q,  out_valid_d;
   logic [PW-1:0]     out_result_q, out_result_d;
   logic [TAG_W-1:0]  out_tag_q,    out_tag_d;

   logic [MW-1:0]     mid_c;
   logic [PW-1:0]     p_c;
   logic [PW-1:0]     prod_c;
   logic [PW-1:0]     result_c;

   // Recombine partial products; the cross-term sum keeps its carry bit
   always_comb begin
      mid_c    = MW'(s2_lh_q) + MW'(s2_hl_q);
      p_c      = {s2_hh_q, WIDTH'(0)} + (PW'(mid_c) << H) + PW'(s2_ll_q);
      prod_c   = s2_neg_q ? (~p_c + PW'(1)) : p_c;
      result_c = prod_c;
      case (s2_mode_q)
         MODE_MADD: result_c = s2_acc_q + prod_c;
         MODE_MSUB: result_c = s2_acc_q - prod_c;
         default:   result_c = prod_c;
      endcase
   end

   // Whole pipe moves together unless a presented result is being held
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_abs_a_d   = s1_abs_a_q;
      s1_abs_b_d   = s1_abs_b_q;
      s1_neg_d     = s1_neg_q;
      s1_mode_d    = s1_mode_q;
      s1_acc_d     = s1_acc_q;
      s1_tag_d     = s1_tag_q;
      s2_valid_d   = s2_valid_q;
      s2_ll_d      = s2_ll_q;
      s2_lh_d      = s2_lh_q;
      s2_hl_d      = s2_hl_q;
      s2_hh_d      = s2_hh_q;
      s2_neg_d     = s2_neg_q;
      s2_mode_d    = s2_mode_q;
      s2_acc_d     = s2_acc_q;
      s2_tag_d     = s2_tag_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_tag_d    = out_tag_q;

      adv    = !(out_valid_q && !out_ready);
      accept = in_valid && adv && !flush;
      sign_a = in_sign & in_a[WIDTH-1];
      sign_b = in_sign & in_b[WIDTH-1];

      if (adv) begin
         s1_valid_d  = accept;
         s1_abs_a_d  = sign_a ? (~in_a + WIDTH'(1)) : in_a;
         s1_abs_b_d  = sign_b ? (~in_b + WIDTH'(1)) : in_b;
         s1_neg_d    = sign_a ^ sign_b;
         s1_mode_d   = mode_e'(in_mode);
         s1_acc_d    = in_acc;
         s1_tag_d    = in_tag;

         s2_valid_d  = s1_valid_q;
         s2_ll_d     = WIDTH'(s1_abs_a_q[H-1:0])     * WIDTH'(s1_abs_b_q[H-1:0]);
         s2_lh_d     = WIDTH'(s1_abs_a_q[H-1:0])     * WIDTH'(s1_abs_b_q[WIDTH-1:H]);
         s2_hl_d     = WIDTH'(s1_abs_a_q[WIDTH-1:H]) * WIDTH'(s1_abs_b_q[H-1:0]);
         s2_hh_d     = WIDTH'(s1_abs_a_q[WIDTH-1:H]) * WIDTH'(s1_abs_b_q[WIDTH-1:H]);
         s2_neg_d    = s1_neg_q;
         s2_mode_d   = s1_mode_q;
         s2_acc_d    = s1_acc_q;
         s2_tag_d    = s1_tag_q;

         out_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            out_result_d = result_c;
            out_tag_d    = s2_tag_q;
         end
      end

      if (flush) begin
         s1_valid_d  = 1'b0;
         s2_valid_d  = 1'b0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid_q   <= 1'b0;
         s1_abs_a_q   <= '0;
         s1_abs_b_q   <= '0;
         s1_neg_q     <= 1'b0;
         s1_mode_q    <= MODE_MUL;
         s1_acc_q     <= '0;
         s1_tag_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_ll_q      <= '0;
         s2_lh_q      <= '0;
         s2_hl_q      <= '0;
         s2_hh_q      <= '0;
         s2_neg_q     <= 1'b0;
         s2_mode_q    <= MODE_MUL;
         s2_acc_q     <= '0;
         s2_tag_q     <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_tag_q    <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_abs_a_q   <= s1_abs_a_d;
         s1_abs_b_q   <= s1_abs_b_d;
         s1_neg_q     <= s1_neg_d;
         s1_mode_q    <= s1_mode_d;
         s1_acc_q     <= s1_acc_d;
         s1_tag_q     <= s1_tag_d;
         s2_valid_q   <= s2_valid_d;
         s2_ll_q      <= s2_ll_d;
         s2_lh_q      <= s2_lh_d;
         s2_hl_q      <= s2_hl_d;
         s2_hh_q      <= s2_hh_d;
         s2_neg_q     <= s2_neg_d;
         s2_mode_q    <= s2_mode_d;
         s2_acc_q     <= s2_acc_d;
         s2_tag_q     <= s2_tag_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_tag_q    <= out_tag_d;
      end
   end

   assign in_ready   = adv;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: directed corner cases plus randomized traffic, all outputs
// checked against a plain-arithmetic reference queue.
module tb_mul_pipe;

   localparam int unsigned W  = 32;
   localparam int unsigned TW = 5;

   logic            clk = 1'b0;
   logic            resetn;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_a;
   logic [W-1:0]    in_b;
   logic            in_sign;
   logic [1:0]      in_mode;
   logic [2*W-1:0]  in_acc;
   logic [TW-1:0]   in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  out_result;
   logic [TW-1:0]   out_tag;

   mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_sign    (in_sign),
      .in_mode    (in_mode),
      .in_acc     (in_acc),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  tag;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_res;
   logic [4:0]  prev_tag;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
      end
   endtask

   // Reference: extend to 64 bits, multiply, accumulate, keep low 64 bits
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic sign, input logic [1:0] mode,
                                         input logic [63:0] acc);
      logic [63:0] ea, eb, prod;
      ea   = sign ? {{32{a[31]}}, a} : {32'd0, a};
      eb   = sign ? {{32{b[31]}}, b} : {32'd0, b};
      prod = ea * eb;
      case (mode)
         2'b01:   return acc + prod;
         2'b10:   return acc - prod;
         default: return prod;
      endcase
   endfunction

   // Scoreboard: sampled mid-cycle, when inputs and outputs are stable
   always @(negedge clk) begin
      if (!resetn) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
         if (prev_stall) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", out_result, prev_res);
            check("hold_tag", 64'(out_tag), 64'(prev_tag));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got result 0x%0h tag %0d, required no output", out_result, out_tag);
            end else begin
               e = q.pop_front();
               check("sb_result", out_result, e.res);
               check("sb_tag", 64'(out_tag), 64'(e.tag));
            end
         end
         prev_stall = out_valid && !out_ready && !flush;
         prev_res   = out_result;
         prev_tag   = out_tag;
         if (flush) q.delete();
         else if (in_valid && in_ready)
            q.push_back('{model(in_a, in_b, in_sign, in_mode, in_acc), in_tag});
      end
   end

   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic sign,
                           input logic [1:0] mode, input logic [63:0] acc, input logic [4:0] tag);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_sign  = sign;
      in_mode  = mode;
      in_acc   = acc;
      in_tag   = tag;
   endtask

   task automatic idle(input int n);
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_accept();
      logic got;
      int   n;
      got = 1'b0;
      n   = 0;
      do begin
         @(negedge clk);
         got = in_ready && !flush;
         @(posedge clk);
         #1;
         n++;
      end while (!got && n < 20);
      check("accept", 64'(got), 64'd1);
   endtask

   // Single op with out_ready=1: presented cycle -> result visible after 3 edges
   task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sign, input logic [1:0] mode, input logic [63:0] acc,
                          input logic [4:0] tag, input logic [63:0] exp);
      int lat;
      out_ready = 1'b1;
      drive_op(a, b, sign, mode, acc, tag);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({name, "_latency"}, 64'(lat), 64'd3);
      check({name, "_result"}, out_result, exp);
      check({name, "_tag"}, 64'(out_tag), 64'(tag));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      resetn    = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sign   = 1'b0;
      in_mode   = 2'b00;
      in_acc    = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_result", out_result, 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      resetn = 1'b1;
      idle(2);

      run_one("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00, 64'd0, 5'd7, 64'hFFFF_FFFE_0000_0001);
      run_one("s_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 2'b00, 64'd0, 5'd1, 64'h4000_0000_0000_0000);
      run_one("s_m1x5", 32'hFFFF_FFFF, 32'd5, 1'b1, 2'b00, 64'd0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFB);
      run_one("s_minx1", 32'h8000_0000, 32'd1, 1'b1, 2'b00, 64'd0, 5'd3, 64'hFFFF_FFFF_8000_0000);
      run_one("u_m1x5", 32'hFFFF_FFFF, 32'd5, 1'b0, 2'b00, 64'd0, 5'd4, 64'h0000_0004_FFFF_FFFB);
      run_one("madd_wrap", 32'd1, 32'd1, 1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'd0);
      run_one("msub_s", 32'd2, 32'd3, 1'b1, 2'b10, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFA);
      run_one("madd_s", 32'hFFFF_FFFE, 32'd3, 1'b1, 2'b01, 64'd10, 5'd8, 64'd4);
      run_one("mode11", 32'd9, 32'd9, 1'b0, 2'b11, 64'd100, 5'd9, 64'd81);

      // Backpressure: stall the first result for 3 cycles
      idle(3);
      fork
         begin
            for (int t = 1; t <= 4; t++) begin
               drive_op(32'(t), 32'(t), 1'b0, 2'b00, 64'd0, 5'(t));
               wait_accept();
            end
            in_valid = 1'b0;
         end
         begin
            int n;
            n = 0;
            while (!out_valid && n < 10) begin
               @(posedge clk);
               #1;
               n++;
            end
            check("bp_first_latency", 64'(n), 64'd3);
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               check("bp_in_ready", 64'(in_ready), 64'd0);
               check("bp_hold_result", out_result, 64'd1);
               check("bp_hold_tag", 64'(out_tag), 64'd1);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
            for (int k = 1; k <= 4; k++) begin
               @(negedge clk);
               check("bp_valid", 64'(out_valid), 64'd1);
               check("bp_result", out_result, 64'(k * k));
               check("bp_tag", 64'(out_tag), 64'(k));
               @(posedge clk);
               #1;
            end
         end
      join
      idle(1);
      check("bp_drained", 64'(out_valid), 64'd0);

      // Flush with a stalled result plus two ops behind it
      idle(3);
      out_ready = 1'b0;
      drive_op(32'd101, 32'd3, 1'b0, 2'b00, 64'd0, 5'd11);
      @(posedge clk); #1;
      drive_op(32'd102, 32'd3, 1'b0, 2'b00, 64'd0, 5'd12);
      @(posedge clk); #1;
      drive_op(32'd103, 32'd3, 1'b0, 2'b00, 64'd0, 5'd13);
      @(posedge clk); #1;
      drive_op(32'd104, 32'd3, 1'b0, 2'b00, 64'd0, 5'd14);
      @(negedge clk);
      check("fl_stalled_valid", 64'(out_valid), 64'd1);
      check("fl_stalled_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b1;
      drive_op(32'd105, 32'd3, 1'b0, 2'b00, 64'd0, 5'd15);
      @(posedge clk); #1;
      check("fl_out_cleared", 64'(out_valid), 64'd0);
      flush     = 1'b0;
      out_ready = 1'b1;
      drive_op(32'd9, 32'd6, 1'b0, 2'b00, 64'd0, 5'd16);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("fl_quiet1", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check("fl_quiet2", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check("fl_new_valid", 64'(out_valid), 64'd1);
      check("fl_new_result", out_result, 64'd54);
      check("fl_new_tag", 64'(out_tag), 64'd16);
      @(posedge clk); #1;
      check("fl_nothing_after", 64'(out_valid), 64'd0);

      // Asynchronous reset between edges with ops in flight
      idle(2);
      drive_op(32'd11, 32'd11, 1'b0, 2'b00, 64'd0, 5'd20);
      @(posedge clk); #1;
      drive_op(32'd12, 32'd11, 1'b0, 2'b00, 64'd0, 5'd21);
      @(posedge clk); #1;
      drive_op(32'd13, 32'd11, 1'b0, 2'b00, 64'd0, 5'd22);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("rm_pre_valid", 64'(out_valid), 64'd1);
      check("rm_pre_result", out_result, 64'd121);
      #2;
      resetn = 1'b0;
      #1;
      check("rm_out_valid", 64'(out_valid), 64'd0);
      check("rm_out_result", out_result, 64'd0);
      check("rm_out_tag", 64'(out_tag), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      resetn = 1'b1;
      idle(1);
      run_one("rm_after", 32'd6, 32'd7, 1'b0, 2'b00, 64'd0, 5'd3, 64'd42);

      // Randomized traffic with random backpressure and occasional flush
      idle(2);
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_a      = pick();
         in_b      = pick();
         in_sign   = 1'($urandom_range(0, 1));
         in_mode   = 2'($urandom_range(0, 3));
         in_acc    = {32'($urandom), 32'($urandom)};
         in_tag    = 5'($urandom_range(0, 31));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         @(posedge clk);
         #1;
      end
      idle(6);
      check("drain_empty", 64'(q.size()), 64'd0);
      check("drain_valid", 64'(out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
